fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/fifo_rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the multi-requester FIFO write arbiter.
package fifo_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_MAX_BURST  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_i, wrapping.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [IW-1:0]      winner_o,
    output logic               any_req_o
);

    logic [IW-1:0] winner;
    logic          found;

    // Offsets 1..NUM_REQ so the previous owner is considered last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(last_i) + k) % NUM_REQ;
            if (!found && req_i[IW'(idx)]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign winner_o  = winner;
    assign any_req_o = found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Bursting round-robin arbiter that funnels several valid/ready requesters into one FIFO write port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q,  last_d;
    logic [BW-1:0] beat_q,  beat_d;

    logic [IW-1:0] pick_winner;
    logic          pick_any;
    logic          own_valid;

    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i     (req_valid),
        .last_i    (last_q),
        .winner_o  (pick_winner),
        .any_req_o (pick_any)
    );

    assign own_valid = req_valid[grant_q];
    assign fifo_din  = words[grant_q];

    // State register; sync reset leaves requester 0 as first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_REQ;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Next state and handshake outputs; rst masks outputs so an aborted beat is never written.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        beat_d     = beat_q;
        busy       = 1'b0;
        fifo_cs    = 1'b0;
        fifo_wr_en = 1'b0;
        req_ready  = '0;
        grant_id   = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_winner;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!rst) begin
                    busy               = 1'b1;
                    fifo_cs            = 1'b1;
                    grant_id           = grant_q;
                    req_ready[grant_q] = !fifo_full;
                    fifo_wr_en         = own_valid && !fifo_full;
                end
                if (!own_valid) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (!fifo_full) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences and a random run against a reference model.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_cs;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_din;
    logic [1:0]        grant_id;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_cs    (fifo_cs),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    // Reference model: owner index (-1 when idle), beats taken, previous owner.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = NR - 1;
    int seq [NR];
    int n_pass = 0;
    int n_checks = 0;
    int dut_writes = 0;
    int model_writes = 0;

    logic          s_busy, s_cs, s_wr;
    logic [NR-1:0] s_rdy;
    logic [1:0]    s_gid;
    logic [DW-1:0] s_din;

    typedef struct {
        logic          r;
        logic [NR-1:0] v;
        logic          f;
        logic          busy;
        logic [1:0]    gid;
        logic          wr;
        logic [NR-1:0] rdy;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [DW-1:0] word_of(input int i);
        return {8'(i), 24'(seq[i])};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // One clock: drive, sample at negedge, compare with model, advance model.
    task automatic cycle(input logic r, input logic [NR-1:0] v, input logic f);
        logic          e_busy, e_wr, own_v, found;
        logic [NR-1:0] e_rdy;
        int            c;
        rst       = r;
        req_valid = v;
        fifo_full = f;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_of(i);
        @(negedge clk);
        s_busy = busy;
        s_cs   = fifo_cs;
        s_wr   = fifo_wr_en;
        s_rdy  = req_ready;
        s_gid  = grant_id;
        s_din  = fifo_din;
        if (s_wr === 1'b1) dut_writes++;

        own_v  = (m_owner >= 0) ? v[m_owner] : 1'b0;
        e_busy = (m_owner >= 0) && !r;
        e_wr   = e_busy && own_v && !f;
        e_rdy  = (e_busy && !f) ? (4'b0001 << m_owner) : 4'b0000;
        chk("busy", 32'(s_busy), 32'(e_busy));
        chk("fifo_cs", 32'(s_cs), 32'(e_busy));
        chk("fifo_wr_en", 32'(s_wr), 32'(e_wr));
        chk("req_ready", 32'(s_rdy), 32'(e_rdy));
        if (e_busy) chk("grant_id", 32'(s_gid), 32'(m_owner));
        if (e_wr) chk("fifo_din", s_din, word_of(m_owner));

        if (r) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = NR - 1;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
                c = (m_last + k) % NR;
                if (!found && v[c]) begin
                    m_owner = c;
                    m_beats = 0;
                    found   = 1'b1;
                end
            end
        end else if (!own_v) begin
            m_last  = m_owner;
            m_owner = -1;
        end else if (!f) begin
            seq[m_owner]++;
            model_writes++;
            m_beats++;
            if (m_beats == MB) begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int            cnt, bcnt;
        logic          prev_busy;
        logic [NR-1:0] rv;
        int            starts [$];

        rst = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        req_data = '0;
        for (int i = 0; i < NR; i++) seq[i] = 0;

        // Requesters 1 and 2 alternate with one idle bubble between bursts.
        tbl[0]  = '{1'b1, 4'b0110, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b0, 4'b0110, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        for (int i = 2; i <= 5; i++) tbl[i] = '{1'b0, 4'b0110, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[6]  = '{1'b0, 4'b0110, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        for (int i = 7; i <= 10; i++) tbl[i] = '{1'b0, 4'b0110, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100};
        tbl[11] = '{1'b0, 4'b0110, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[12] = '{1'b0, 4'b0110, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010};
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].f);
            chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_wr", i), 32'(s_wr), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d_rdy", i), 32'(s_rdy), 32'(tbl[i].rdy));
            if (tbl[i].busy) chk($sformatf("tbl%0d_gid", i), 32'(s_gid), 32'(tbl[i].gid));
        end

        // All four requesting: one full rotation then wrap to 0.
        cycle(1'b1, 4'b0000, 1'b0);
        cnt = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 22; i++) begin
            cycle(1'b0, 4'b1111, 1'b0);
            if (i < 21 && s_wr === 1'b1) cnt++;
            if (s_busy === 1'b1 && !prev_busy) starts.push_back(int'(s_gid));
            prev_busy = s_busy;
        end
        chk("rot_wr_pulses", 32'(cnt), 32'd16);
        chk("rot_grant_count", 32'(starts.size()), 32'd5);
        for (int i = 0; i < 5 && i < starts.size(); i++)
            chk($sformatf("rot_grant%0d", i), 32'(starts[i]), 32'(i % NR));

        // Owner 2 stalled by a full FIFO after its first beat.
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0100, 1'b0);
        chk("stall_idle", 32'(s_busy), 32'd0);
        cycle(1'b0, 4'b0100, 1'b0);
        chk("stall_beat1", 32'(s_wr), 32'd1);
        chk("stall_owner", 32'(s_gid), 32'd2);
        cnt = 0;
        bcnt = 0;
        repeat (3) begin
            cycle(1'b0, 4'b0100, 1'b1);
            cnt += int'(s_wr);
            bcnt += int'(s_busy);
        end
        chk("stall_no_wr", 32'(cnt), 32'd0);
        chk("stall_hold", 32'(bcnt), 32'd3);
        cnt = 0;
        repeat (3) begin
            cycle(1'b0, 4'b0100, 1'b0);
            cnt += int'(s_wr);
        end
        chk("stall_beats234", 32'(cnt), 32'd3);
        cycle(1'b0, 4'b0000, 1'b0);
        chk("stall_release", 32'(s_busy), 32'd0);

        // Owner 0 drops valid after two beats.
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b1011, 1'b0);
        cycle(1'b0, 4'b1011, 1'b0);
        chk("drop_owner", 32'(s_gid), 32'd0);
        cycle(1'b0, 4'b1011, 1'b0);
        chk("drop_beat2", 32'(s_wr), 32'd1);
        cycle(1'b0, 4'b1010, 1'b0);
        chk("drop_no_wr", 32'(s_wr), 32'd0);
        cycle(1'b0, 4'b1010, 1'b0);
        chk("drop_idle", 32'(s_busy), 32'd0);
        cycle(1'b0, 4'b1010, 1'b0);
        chk("drop_next", 32'(s_gid), 32'd1);

        // Reset during beat 3 of owner 1.
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0);
        chk("rst_owner", 32'(s_gid), 32'd1);
        cycle(1'b1, 4'b0010, 1'b0);
        chk("rst_no_wr", 32'(s_wr), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_ready", 32'(s_rdy), 32'd0);
        chk("rst_cs", 32'(s_cs), 32'd0);
        cycle(1'b0, 4'b0011, 1'b0);
        cycle(1'b0, 4'b0011, 1'b0);
        chk("rst_next", 32'(s_gid), 32'd0);

        // Randomized traffic, backpressure and occasional reset.
        rv = '0;
        cycle(1'b1, rv, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < NR; b++)
                if ($urandom_range(0, 7) == 0) rv[b] = ~rv[b];
            cycle($urandom_range(0, 299) == 0, rv, $urandom_range(0, 3) == 0);
        end

        chk("sb_write_count", 32'(dut_writes), 32'(model_writes));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
